md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage beside the ALU.
//  Executes MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO reads using the forwarded operands SrcAE/SrcBE.
//  Its MdStallE output is ORed into the hazard unit's stall equation (StallF/StallD/FlushE) while HI/LO is pending.
// PARAMETERS
//  DATA_WIDTH  32  operand and HI/LO width; iteration count = DATA_WIDTH
// PORTS
//  clk       in   1           single clock; all state updates on rising edge
//  rst       in   1           synchronous, active-high reset
//  MdOpE     in   3           EX op: 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI/MFLO
//  SrcAE     in   DATA_WIDTH  rs operand (post-forwarding)
//  SrcBE     in   DATA_WIDTH  rt operand (post-forwarding)
//  HiE       out  DATA_WIDTH  current HI register (registered)
//  LoE       out  DATA_WIDTH  current LO register (registered)
//  MdBusy    out  1           high while an operation is in flight (state != IDLE)
//  MdStallE  out  1           comb: MdBusy && (MdOpE != 0); request to stall F/D and flush E
// BEHAVIOUR
//  - Reset: state IDLE, HI=0, LO=0, counter=0, MdBusy=0. Reset mid-operation aborts it: no HI/LO write.
//  - FSM: IDLE -> MUL or DIV on accept -> FIX -> IDLE. No other transitions.
//  - Accept: only in IDLE with MdOpE in 1..4. Latch |SrcAE| and |SrcBE| (magnitudes for 1/3; raw for 2/4).
//    Latch both sign bits. Clear counter.
//  - MUL: radix-2 shift-add, one bit per cycle, DATA_WIDTH cycles, 2*DATA_WIDTH-bit accumulator.
//  - DIV: radix-2 restoring, one quotient bit per cycle, DATA_WIDTH cycles.
//  - FIX (1 cycle): sign correction, then write HI/LO.
//    Signed MULT: negate the 64-bit product if the signs differ. HI = upper half, LO = lower half.
//    Signed DIV: negate the quotient if the signs differ. Remainder takes the dividend's sign.
//    Division: LO = quotient, HI = remainder.
//  - Latency: accept in cycle T. MdBusy=1 in T+1..T+DATA_WIDTH+1. HI/LO updated at the end of T+DATA_WIDTH+1.
//    New values are visible on HiE/LoE at T+DATA_WIDTH+2, which is also the first IDLE cycle.
//  - MdStallE=0 in the accept cycle, so the issuing instruction leaves EX.
//    Later instructions with MdOpE=0 proceed unstalled while MdBusy.
//    Any MdOpE!=0 while busy stalls and holds in EX until IDLE.
//    It is then processed in that IDLE cycle, so a back-to-back op starts with zero gap.
//  - MTHI/MTLO in IDLE: HI/LO <= SrcAE at that clock edge. Single cycle, MdBusy stays 0.
//  - MFHI/MFLO (op 7): no state change. Stalls only while busy; the EX result mux reads HiE/LoE.
//  - Operands and MdOpE are ignored while busy; latched values alone drive the computation.
//  - Divide by zero, restoring result: LO = all ones; HI = dividend magnitude, sign-corrected for DIV. No exception.
//  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
//  - Counter is clog2(DATA_WIDTH)+1 bits. Terminal count DATA_WIDTH-1 moves to FIX. No wrap in normal use.
//  - An FlushE-driven bubble (MdOpE=0) never cancels an accepted operation.
// TESTING
//  1. MULT 0xFFFFFFFE*0x00000003 -> MdBusy high exactly 33 cycles; HI=FFFFFFFF LO=FFFFFFFA at T+34.
//  2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=FFFFFFFE LO=00000001. MULT same operands -> HI=0 LO=1.
//  3. DIV -7/2 -> LO=FFFFFFFD HI=FFFFFFFF. DIV 7/-2 -> LO=FFFFFFFD HI=00000001.
//     DIVU 0xFFFFFFFF/0x10 -> LO=0FFFFFFF HI=F.
//  4. DIVU 100/0 -> LO=FFFFFFFF HI=00000064. DIV 0x80000000/0xFFFFFFFF -> LO=80000000 HI=0.
//  5. MULT accepted, then MFHI presented at T+1 -> MdStallE=1 T+1..T+33, 0 at T+34.
//     MTLO 0x1234 held in EX while busy -> LO=0x1234 after first IDLE edge, HI = product.
//  6. rst asserted in cycle T+10 of a DIV -> next cycle IDLE, MdBusy=0, HI=LO=0.
//     A MULT in the following cycle is accepted normally.

Source files
------------

// File: rtl/md_unit.sv
// md_unit -- iterative multiply/divide unit with architectural HI/LO registers.
// Sits in EX beside the ALU. Runs MULT/MULTU/DIV/DIVU one bit per cycle,
// performs MTHI/MTLO writes in a single cycle, and raises a stall request
// while an operation is in flight and a later instruction needs the unit.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   MdOpE     EX op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI/MFLO
//   SrcAE     rs operand (post-forwarding)
//   SrcBE     rt operand (post-forwarding)
//   HiE/LoE   current HI/LO registers
//   MdBusy    operation in flight (state != IDLE)
//   MdStallE  MdBusy && MdOpE != 0; stall F/D and flush E
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready; accepts MULT/DIV, performs MTHI/MTLO
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | sign correction and HI/LO write

module md_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            MdOpE,
   input  logic [DATA_WIDTH-1:0] SrcAE,
   input  logic [DATA_WIDTH-1:0] SrcBE,
   output logic [DATA_WIDTH-1:0] HiE,
   output logic [DATA_WIDTH-1:0] LoE,
   output logic                  MdBusy,
   output logic                  MdStallE
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]   hi_q, lo_q;
   // MUL: {partial product high, remaining multiplier bits}
   // DIV: {partial remainder, dividend bits / quotient bits}
   logic [2*W-1:0] acc_q;
   logic [W-1:0]   mcand_q;
   logic [CW-1:0]  cnt_q;
   logic           sign_a_q, sign_b_q, signed_q, is_mul_q;

   logic           accept, op_is_mul, op_is_signed;
   logic [W-1:0]   a_mag, b_mag;
   logic [W:0]     mul_sum;
   logic [W:0]     div_shift;
   logic           div_neg;
   logic [W-1:0]   div_sub;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo, rem, quo_fix, rem_fix;
   logic           div_by_zero;

   assign accept       = (state_q == S_IDLE) && (MdOpE >= OP_MULT) && (MdOpE <= OP_DIVU);
   assign op_is_mul    = (MdOpE == OP_MULT) || (MdOpE == OP_MULTU);
   assign op_is_signed = (MdOpE == OP_MULT) || (MdOpE == OP_DIV);
   assign a_mag        = (op_is_signed && SrcAE[W-1]) ? -SrcAE : SrcAE;
   assign b_mag        = (op_is_signed && SrcBE[W-1]) ? -SrcBE : SrcBE;

   // W+1-bit sum keeps the carry that shifts into the accumulator top bit
   assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});

   // Restoring step: the remainder always stays below the divisor, so the
   // subtraction result fits in W bits whenever it is kept.
   assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
   assign div_neg   = div_shift < {1'b0, mcand_q};
   assign div_sub   = div_shift[W-1:0] - mcand_q;
   assign div_rem   = div_neg ? div_shift[W-1:0] : div_sub;

   assign prod_fix    = (signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
   assign quo         = acc_q[W-1:0];
   assign rem         = acc_q[2*W-1:W];
   assign div_by_zero = (mcand_q == '0);
   // Divide by zero leaves the all-ones quotient untouched
   assign quo_fix     = (signed_q && (sign_a_q ^ sign_b_q) && !div_by_zero) ? -quo : quo;
   assign rem_fix     = (signed_q && sign_a_q) ? -rem : rem;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = op_is_mul ? S_MUL : S_DIV;
         S_MUL,
         S_DIV:   if (cnt_q == CNT_LAST) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         signed_q <= 1'b0;
         is_mul_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  acc_q    <= {{W{1'b0}}, (op_is_mul ? b_mag : a_mag)};
                  mcand_q  <= op_is_mul ? a_mag : b_mag;
                  sign_a_q <= SrcAE[W-1];
                  sign_b_q <= SrcBE[W-1];
                  signed_q <= op_is_signed;
                  is_mul_q <= op_is_mul;
                  cnt_q    <= '0;
               end else if (MdOpE == OP_MTHI) begin
                  hi_q <= SrcAE;
               end else if (MdOpE == OP_MTLO) begin
                  lo_q <= SrcAE;
               end
            end
            S_MUL: begin
               acc_q <= {mul_sum, acc_q[W-1:1]};
               cnt_q <= cnt_q + CW'(1);
            end
            S_DIV: begin
               acc_q <= {div_rem, acc_q[W-2:0], ~div_neg};
               cnt_q <= cnt_q + CW'(1);
            end
            S_FIX: begin
               if (is_mul_q) begin
                  hi_q <= prod_fix[2*W-1:W];
                  lo_q <= prod_fix[W-1:0];
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign HiE      = hi_q;
   assign LoE      = lo_q;
   assign MdBusy   = (state_q != S_IDLE);
   assign MdStallE = MdBusy && (MdOpE != 3'd0);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed operations push expected HI/LO and busy length
// into a scoreboard; a monitor pops and compares each time MdBusy falls.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  MdOpE;
   logic [31:0] SrcAE, SrcBE;
   logic [31:0] HiE, LoE;
   logic        MdBusy, MdStallE;

   int checks = 0;
   int errors = 0;
   int busy_len = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
      string       name;
   } exp_t;

   exp_t sb[$];

   md_unit #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .MdOpE    (MdOpE),
      .SrcAE    (SrcAE),
      .SrcBE    (SrcBE),
      .HiE      (HiE),
      .LoE      (LoE),
      .MdBusy   (MdBusy),
      .MdStallE (MdStallE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int len);
      exp_t e;
      e.hi = hi; e.lo = lo; e.len = len; e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: completion is the falling edge of MdBusy
   always @(negedge clk) begin
      if (MdBusy === 1'b1) begin
         busy_len++;
      end else if (busy_len > 0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: completion with empty scoreboard, hi %h lo %h", HiE, LoE);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_hi"}, HiE, e.hi);
            chk({e.name, "_lo"}, LoE, e.lo);
            chk({e.name, "_busy_len"}, 32'(busy_len), 32'(e.len));
         end
         busy_len = 0;
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while (MdBusy !== 1'b0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (MdBusy !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: MdBusy %b after %0d cycles, expected 0", name, MdBusy, n);
      end
   endtask

   // Issue in the current cycle (T); operands are scrambled afterwards since
   // the unit must work only from its latched copies.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
      push(name, hi, lo, 33);
      MdOpE = op; SrcAE = a; SrcBE = b;
      @(posedge clk); #1;
      MdOpE = 3'd0; SrcAE = $urandom; SrcBE = $urandom;
      wait_idle(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; MdOpE = 3'd0; SrcAE = '0; SrcBE = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      MdOpE = 3'd7;
      #1;
      chk("reset_hi", HiE, 32'h0);
      chk("reset_lo", LoE, 32'h0);
      chk("reset_busy", {31'b0, MdBusy}, 32'h0);
      chk("reset_stall", {31'b0, MdStallE}, 32'h0);
      MdOpE = 3'd0;
      @(posedge clk); #1;

      run_op("mult_neg",   3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_ones",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
      run_op("multu_shift",3'd2, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
      run_op("div_m7_2",   3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7_m2",   3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("divu_big",   3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
      run_op("div_100_7",  3'd3, 32'd100,      32'd7,        32'd2,        32'd14);
      run_op("divu_zero",  3'd4, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
      run_op("div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // MTHI / MTLO in IDLE
      MdOpE = 3'd5; SrcAE = 32'hAABBCCDD;
      @(posedge clk); #1;
      MdOpE = 3'd6; SrcAE = 32'h11223344;
      chk("mthi_hi", HiE, 32'hAABBCCDD);
      chk("mthi_busy", {31'b0, MdBusy}, 32'h0);
      @(posedge clk); #1;
      MdOpE = 3'd0;
      chk("mtlo_lo", LoE, 32'h11223344);
      chk("mtlo_hi_kept", HiE, 32'hAABBCCDD);

      // MFHI right behind a MULT: stalls exactly through the busy window
      push("mult_mfhi", 32'hFFFFFFFF, 32'hFFFFFFFA, 33);
      MdOpE = 3'd1; SrcAE = 32'hFFFFFFFE; SrcBE = 32'h00000003;
      #1 chk("stall_accept", {31'b0, MdStallE}, 32'h0);
      @(posedge clk); #1;
      MdOpE = 3'd7; SrcAE = $urandom; SrcBE = $urandom;
      #1;
      n = 0;
      while (MdStallE === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #2;
      end
      chk("mfhi_stall_len", 32'(n), 32'd33);
      chk("mfhi_idle_busy", {31'b0, MdBusy}, 32'h0);
      chk("mfhi_hi_visible", HiE, 32'hFFFFFFFF);
      MdOpE = 3'd0;

      // MTLO held in EX while busy, processed in the first IDLE cycle
      push("multu_mtlo", 32'h00000003, 32'h00000000, 33);
      MdOpE = 3'd2; SrcAE = 32'h00010000; SrcBE = 32'h00030000;
      @(posedge clk); #1;
      MdOpE = 3'd6; SrcAE = 32'h00001234; SrcBE = 32'h0;
      #1 chk("mtlo_stall_busy", {31'b0, MdStallE}, 32'h1);
      wait_idle("multu_mtlo");
      @(posedge clk); #1;
      MdOpE = 3'd0;
      chk("mtlo_after_lo", LoE, 32'h00001234);
      chk("mtlo_after_hi", HiE, 32'h00000003);
      chk("mtlo_after_busy", {31'b0, MdBusy}, 32'h0);

      // Reset in cycle T+10 of a DIV aborts it
      push("div_abort", 32'h0, 32'h0, 10);
      MdOpE = 3'd3; SrcAE = 32'd100; SrcBE = 32'd7;
      @(posedge clk); #1;
      MdOpE = 3'd0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'b0, MdBusy}, 32'h0);
      chk("abort_hi", HiE, 32'h0);
      chk("abort_lo", LoE, 32'h0);
      run_op("mult_after_rst", 3'd1, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6);

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
